shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle shift/rotate engine built around a single 1-bit-per-cycle
//   shift datapath (LSL, LSR, ASR, ROL, ROR). Accepts one operand, opcode and
//   shift amount per transaction over a valid/ready handshake. Applies the
//   selected 1-bit operation once per clock, amt times, then presents the
//   result on a valid/ready output. Sits between a command source and its
//   consumer in place of a wide barrel shifter.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
//   AMT_W  3  shift-amount width; legal amounts 0 .. 2**AMT_W-1
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      command valid
//   in_ready   out  1      command accepted when in_valid & in_ready
//   in_data    in   WIDTH  operand (signed for ASR)
//   in_op      in   3      0=LSL 1=LSR 2=ASR 3=ROL 4=ROR, 5-7 illegal
//   in_amt     in   AMT_W  number of 1-bit steps
//   out_valid  out  1      result valid
//   out_ready  in   1      result consumed when out_valid & out_ready
//   out_data   out  WIDTH  result
//   out_err    out  1      result is from an illegal opcode; qualified by out_valid
//   busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
// - Reset: state=IDLE; out_valid=0, out_data=0, out_err=0, busy=0, step counter=0.
//   in_ready=1 from the first cycle after rst deasserts.
// - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: in_ready=1. On accept, latch data/op/amt.
//     - Legal op, amt>0: go to SHIFT with cnt=amt.
//     - amt==0 or illegal op: go to DONE with data unchanged.
//     - Illegal op sets the err latch; legal op clears it.
//   - SHIFT: in_ready=0. Each cycle apply one step and decrement cnt.
//     Go to DONE in the cycle the step for cnt==1 is applied.
//   - DONE: out_valid=1, out_data/out_err held stable until out_ready.
//     On handshake go to IDLE; in_ready rises the following cycle.
//     No accept is possible in DONE, so transactions never overlap.
// - One step, with d = current value and W = WIDTH:
//   - LSL = {d[W-2:0],1'b0}
//   - LSR = {1'b0,d[W-1:1]}
//   - ASR = {d[W-1],d[W-1:1]}
//   - ROL = {d[W-2:0],d[W-1]}
//   - ROR = {d[0],d[W-1:1]}
// - Latency: accept in cycle N, out_valid first high in cycle N+1+amt.
//   amt=0 gives N+1. An illegal op always gives N+1.
// - Amounts >= WIDTH are legal and not clamped:
//   - LSL/LSR produce 0.
//   - ASR produces all sign bits.
//   - Rotates wrap modulo WIDTH.
// - out_valid is deasserted in the cycle after the output handshake.
//   out_data keeps its last value and is don't-care.
// - rst asserted in any state, including mid-SHIFT or DONE with out_valid=1:
//   the transaction is discarded, no output handshake occurs,
//   and all registers return to reset values next edge.
// TESTING
//   1 LSL, 0x81, amt=3 -> out_data=0x08, out_err=0, out_valid high 4 cycles after accept
//   2 ASR, 0x90, amt=2 -> 0xE4. ROR, 0x01, amt=1 -> 0x80. ROL, 0x81, amt=7 -> 0xC0
//   3 LSR, 0xA5, amt=0 -> 0xA5 one cycle after accept.
//     op=6, 0x3C, amt=5 -> out_data=0x3C, out_err=1, latency 1
//   4 Backpressure: 0x81 LSL amt 3 -> out_ready low 5 cycles.
//     out_data=0x08 stable, in_ready=0, busy=1; then handshake -> in_ready=1 next cycle
//   5 rst pulse at 2nd SHIFT cycle of ROL amt 7 -> next cycle out_valid=0, busy=0.
//     New LSL 0x01 amt 1 -> 0x02
//   6 in_valid held high across 3 back-to-back commands:
//     each accepted only in IDLE, results in order, none dropped or duplicated

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: one 1-bit LSL/LSR/ASR/ROL/ROR step per clock,
// amt steps per transaction, valid/ready on both command and result sides.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_legal_c;

  // Single 1-bit step of the selected operation.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d,
                                             input logic [2:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_LSL:  r = {d[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, d[WIDTH-1:1]};
      OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign in_legal_c = (in_op <= OP_ROR);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d = in_data;
          op_d   = in_op;
          cnt_d  = in_amt;
          err_d  = !in_legal_c;
          if (in_legal_c && (in_amt != '0)) state_d = SHIFT;
          else                              state_d = DONE;
        end
      end
      SHIFT: begin
        data_d = step1(data_q, op_q);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: results, latency, illegal ops,
// backpressure, mid-transaction reset and back-to-back commands.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  int tests = 0;
  int fails = 0;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and return #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] amt);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_accept: command not accepted in 50 cycles");
    end
  endtask

  // Wait for out_valid; lat=1 means valid in the cycle right after accept.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Check one transaction's result, latency and the handshake aftermath.
  task automatic run_one(input string name, input logic [2:0] op, input logic [7:0] d,
                         input logic [2:0] amt, input logic [7:0] exp_d,
                         input logic exp_err, input int exp_lat);
    int lat;
    send(op, d, amt);
    wait_result(lat);
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests++;
    if (out_data !== exp_d || out_err !== exp_err) begin
      fails++;
      $display("FAIL %s_data: got %h err %b expected %h err %b", name, out_data, out_err, exp_d, exp_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_release: out_valid %b in_ready %b busy %b expected 0 1 0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: ov %b busy %b data %h err %b ir %b expected 0 0 00 0 1", out_valid, busy, out_data, out_err, in_ready);
    end
  endtask

  task automatic test_ops();
    run_one("lsl3",  3'd0, 8'h81, 3'd3, 8'h08, 1'b0, 4);
    run_one("asr2",  3'd2, 8'h90, 3'd2, 8'hE4, 1'b0, 3);
    run_one("ror1",  3'd4, 8'h01, 3'd1, 8'h80, 1'b0, 2);
    run_one("rol7",  3'd3, 8'h81, 3'd7, 8'hC0, 1'b0, 8);
    run_one("lsr7",  3'd1, 8'h80, 3'd7, 8'h01, 1'b0, 8);
    run_one("asr7",  3'd2, 8'h80, 3'd7, 8'hFF, 1'b0, 8);
  endtask

  task automatic test_zero_and_illegal();
    run_one("lsr0",  3'd1, 8'hA5, 3'd0, 8'hA5, 1'b0, 1);
    run_one("ill6",  3'd6, 8'h3C, 3'd5, 8'h3C, 1'b1, 1);
    run_one("ill7",  3'd7, 8'h5A, 3'd0, 8'h5A, 1'b1, 1);
    run_one("clr",   3'd0, 8'h01, 3'd2, 8'h04, 1'b0, 3);
  endtask

  task automatic test_backpressure();
    int lat;
    send(3'd0, 8'h81, 3'd3);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h08 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d: ov %b data %h ir %b busy %b expected 1 08 0 1", i, out_valid, out_data, in_ready, busy);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: ir %b ov %b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    send(3'd3, 8'h81, 3'd7);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: ov %b busy %b ir %b data %h expected 0 0 1 00", out_valid, busy, in_ready, out_data);
    end
    run_one("post_rst", 3'd0, 8'h01, 3'd1, 8'h02, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    logic [2:0] c_op  [3] = '{3'd0, 3'd4, 3'd2};
    logic [7:0] c_dat [3] = '{8'h03, 8'h0F, 8'h40};
    logic [2:0] c_amt [3] = '{3'd2, 3'd4, 3'd1};
    logic [7:0] c_exp [3] = '{8'h0C, 8'hF0, 8'h20};
    int idx = 0;
    int ridx = 0;
    bit acc, hs;
    in_valid = 1'b1; in_op = c_op[0]; in_data = c_dat[0]; in_amt = c_amt[0];
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && ridx < 3; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (acc) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL b2b_accept_idle: busy %b at accept expected 0", busy);
        end
      end
      if (hs) begin
        tests++;
        if (out_data !== c_exp[ridx] || out_err !== 1'b0) begin
          fails++;
          $display("FAIL b2b_result%0d: got %h err %b expected %h err 0", ridx, out_data, out_err, c_exp[ridx]);
        end
        ridx++;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_op = c_op[idx]; in_data = c_dat[idx]; in_amt = c_amt[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    tests++;
    if (ridx != 3 || idx != 3) begin
      fails++;
      $display("FAIL b2b_count: results %0d accepts %0d expected 3 3", ridx, idx);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_extra: out_valid %b expected 0", out_valid);
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_zero_and_illegal();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
